// File: rtl/ccpd_scan_seq.sv
// ccpd_scan_seq: CCPD injection-scan sequencer (SPI config load, settle, N injections per step).
// Define SCAN_TIMEOUT_EN to add a watchdog on the SPI/injection done-waits (drives ERROR).
module ccpd_scan_seq #(
  parameter int STEP_WIDTH     = 16,
  parameter int INJ_WIDTH      = 8,
  parameter int SETTLE_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [STEP_WIDTH-1:0]   NUM_STEPS,
  input  logic [INJ_WIDTH-1:0]    NUM_INJ,
  input  logic [SETTLE_WIDTH-1:0] SETTLE_CYCLES,
  output logic                    SPI_START,
  input  logic                    SPI_DONE,
  output logic                    INJ_START,
  input  logic                    INJ_DONE,
  input  logic                    FIFO_NEAR_FULL,
  output logic                    BUSY,
  output logic                    SCAN_DONE,
  output logic [STEP_WIDTH-1:0]   STEP,
  output logic [INJ_WIDTH-1:0]    INJ_COUNT,
  output logic                    ERROR
);

  typedef enum logic [2:0] {IDLE, LOAD, LOAD_WAIT, SETTLE, INJ, INJ_WAIT, NEXT} state_e;

  localparam logic [STEP_WIDTH-1:0]   StepOne   = 1;
  localparam logic [INJ_WIDTH-1:0]    InjOne    = 1;
  localparam logic [SETTLE_WIDTH-1:0] SettleOne = 1;

  state_e                  state_q, state_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d, numSteps_q, numSteps_d;
  logic [INJ_WIDTH-1:0]    injCnt_q, injCnt_d, numInj_q, numInj_d;
  logic [SETTLE_WIDTH-1:0] settleCnt_q, settleCnt_d, settleCycles_q, settleCycles_d;
  logic                    waitFirst_q, waitFirst_d;
  logic                    scanDone_q, scanDone_d;
  logic                    doneSel;

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] waitCnt_q, waitCnt_d;
  logic          error_q, error_d;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    injCnt_d       = injCnt_q;
    settleCnt_d    = settleCnt_q;
    numSteps_d     = numSteps_q;
    numInj_d       = numInj_q;
    settleCycles_d = settleCycles_q;
    waitFirst_d    = 1'b0;
    scanDone_d     = 1'b0;
`ifdef SCAN_TIMEOUT_EN
    waitCnt_d      = '0;
    error_d        = error_q;
`endif
    doneSel = (state_q == LOAD_WAIT) ? SPI_DONE : INJ_DONE;

    case (state_q)
      IDLE: begin
        if (START) begin
          numSteps_d     = NUM_STEPS;
          numInj_d       = NUM_INJ;
          settleCycles_d = SETTLE_CYCLES;
`ifdef SCAN_TIMEOUT_EN
          error_d        = 1'b0;
`endif
          if (NUM_STEPS == '0) begin
            scanDone_d = 1'b1;
          end else begin
            state_d  = LOAD;
            step_d   = '0;
            injCnt_d = '0;
          end
        end
      end
      LOAD: begin
        state_d     = LOAD_WAIT;
        waitFirst_d = 1'b1;
      end
      // Done is a ready level that may still be high from the previous
      // transaction during the first wait cycle, so that cycle is masked.
      LOAD_WAIT, INJ_WAIT: begin
`ifdef SCAN_TIMEOUT_EN
        waitCnt_d = waitCnt_q + 1'b1;
`endif
        if (!waitFirst_q && doneSel) begin
          if (state_q == LOAD_WAIT) begin
            state_d     = SETTLE;
            settleCnt_d = settleCycles_q;
          end else begin
            state_d = (injCnt_q < numInj_q) ? INJ : NEXT;
          end
        end
`ifdef SCAN_TIMEOUT_EN
        else if (waitCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      SETTLE: begin
        if (settleCnt_q <= SettleOne) begin
          state_d = (injCnt_q == numInj_q) ? NEXT : INJ;
        end else begin
          settleCnt_d = settleCnt_q - SettleOne;
        end
      end
      INJ: begin
        if (!FIFO_NEAR_FULL) begin
          injCnt_d    = injCnt_q + InjOne;
          state_d     = INJ_WAIT;
          waitFirst_d = 1'b1;
        end
      end
      NEXT: begin
        if (step_q == numSteps_q - StepOne) begin
          state_d    = IDLE;
          scanDone_d = 1'b1;
        end else begin
          step_d   = step_q + StepOne;
          injCnt_d = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort freezes everything except the state so the counters remain readable.
    if (ABORT) begin
      state_d        = IDLE;
      step_d         = step_q;
      injCnt_d       = injCnt_q;
      settleCnt_d    = settleCnt_q;
      numSteps_d     = numSteps_q;
      numInj_d       = numInj_q;
      settleCycles_d = settleCycles_q;
      waitFirst_d    = 1'b0;
      scanDone_d     = 1'b0;
`ifdef SCAN_TIMEOUT_EN
      waitCnt_d      = '0;
      error_d        = error_q;
`endif
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
    if (!BUS_RST) begin
      state_q        <= IDLE;
      step_q         <= '0;
      injCnt_q       <= '0;
      settleCnt_q    <= '0;
      numSteps_q     <= '0;
      numInj_q       <= '0;
      settleCycles_q <= '0;
      waitFirst_q    <= 1'b0;
      scanDone_q     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      waitCnt_q      <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      injCnt_q       <= injCnt_d;
      settleCnt_q    <= settleCnt_d;
      numSteps_q     <= numSteps_d;
      numInj_q       <= numInj_d;
      settleCycles_q <= settleCycles_d;
      waitFirst_q    <= waitFirst_d;
      scanDone_q     <= scanDone_d;
`ifdef SCAN_TIMEOUT_EN
      waitCnt_q      <= waitCnt_d;
      error_q        <= error_d;
`endif
    end
  end

  assign SPI_START = (state_q == LOAD);
  assign INJ_START = (state_q == INJ) && !FIFO_NEAR_FULL;
  assign BUSY      = (state_q != IDLE);
  assign SCAN_DONE = scanDone_q;
  assign STEP      = step_q;
  assign INJ_COUNT = injCnt_q;
`ifdef SCAN_TIMEOUT_EN
  assign ERROR     = error_q;
`else
  assign ERROR     = 1'b0;
`endif

endmodule

// File: doc/ccpd_scan_seq.md
Name: ccpd_scan_seq

Overview:
Sequencer for CCPD injection scans. For each scan step it:
- triggers a configuration shift-register load through the SPI master's start strobe and waits for done;
- waits a programmable settle time;
- fires N injection/gate bursts through the pulse generator's start strobe, waiting for each to complete.

It sits between the USB bus-controlled configuration and the CCPD SPI/pulse-gen blocks. It stalls injections while the readout SRAM FIFO is near full, so TDC/SPI-RX data are never dropped.

Parameters:
STEP_WIDTH, 16, width of step counter and NUM_STEPS
INJ_WIDTH, 8, width of injection counter and NUM_INJ
SETTLE_WIDTH, 16, width of settle counter
TIMEOUT_CYCLES, 65535, watchdog limit on any done-wait (only with SCAN_TIMEOUT_EN)

Ports:
BUS_CLK  in  1  single clock, all logic on rising edge
BUS_RST  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse; begins scan when idle, ignored when busy
ABORT  in  1  level/pulse; returns FSM to IDLE at next edge
NUM_STEPS  in  STEP_WIDTH  number of steps; 0 = no-op scan
NUM_INJ  in  INJ_WIDTH  injections per step; 0 = load-only steps
SETTLE_CYCLES  in  SETTLE_WIDTH  cycles between load done and first injection
SPI_START  out  1  one-cycle strobe to SPI master
SPI_DONE  in  1  SPI master ready/done level
INJ_START  out  1  one-cycle strobe to pulse generator
INJ_DONE  in  1  pulse generator ready/done level
FIFO_NEAR_FULL  in  1  readout backpressure
BUSY  out  1  high whenever state != IDLE
SCAN_DONE  out  1  one-cycle pulse on normal completion
STEP  out  STEP_WIDTH  current step index
INJ_COUNT  out  INJ_WIDTH  injections issued in current step
ERROR  out  1  sticky watchdog flag (0 when SCAN_TIMEOUT_EN undefined)

Behaviour:
- Reset (BUS_RST=0, async): state IDLE; all counters 0; all outputs 0. Operation resumes on the first edge after deassertion.
- NUM_STEPS, NUM_INJ and SETTLE_CYCLES are latched on the accepted START; later changes have no effect until the next START.
- IDLE:
  - START=1 and NUM_STEPS=0 → SCAN_DONE the next cycle, stay IDLE.
  - START=1 and NUM_STEPS>0 → LOAD; clear STEP, INJ_COUNT and ERROR.
- LOAD: assert SPI_START for exactly 1 cycle → LOAD_WAIT.
- LOAD_WAIT:
  - Ignore SPI_DONE in the first cycle; the done input may lag the start by one cycle.
  - SPI_DONE=1 → SETTLE and load the settle counter.
- SETTLE:
  - Counts SETTLE_CYCLES cycles; 0 means leave after exactly 1 cycle.
  - When the count completes: INJ_COUNT==NUM_INJ → NEXT; otherwise → INJ.
- INJ:
  - FIFO_NEAR_FULL=1 → hold with no strobe.
  - Otherwise assert INJ_START for 1 cycle, INJ_COUNT+1 → INJ_WAIT.
- INJ_WAIT: same first-cycle masking as LOAD_WAIT. INJ_DONE=1 → INJ if INJ_COUNT<NUM_INJ, otherwise NEXT.
- NEXT:
  - STEP==NUM_STEPS-1 → SCAN_DONE pulse → IDLE.
  - Otherwise STEP+1, INJ_COUNT=0 → LOAD.
- Latency: START → SPI_START is exactly 1 cycle.
- Strobes are mutually exclusive and never back-to-back.
- ABORT has priority over every transition, including START in the same cycle:
  - next state IDLE, no SCAN_DONE;
  - STEP and INJ_COUNT keep their values for debug;
  - a strobe already issued is not retracted.
- STEP never wraps; NUM_STEPS=2^STEP_WIDTH-1 is the maximum.

Optional Feature:
SCAN_TIMEOUT_EN
- Defined:
  - a wait counter runs in LOAD_WAIT and INJ_WAIT;
  - reaching TIMEOUT_CYCLES without done sets ERROR (sticky until the next accepted START) and forces IDLE without SCAN_DONE.
- Undefined: no counter; ERROR tied to 0; waits are unbounded.

Test Plan:
- NUM_STEPS=3, NUM_INJ=2, SETTLE=4, done returned 2 cycles after each strobe → 3 SPI_START pulses, 6 INJ_START pulses, SCAN_DONE once, BUSY low the cycle after SCAN_DONE.
- START with NUM_STEPS=0 → SCAN_DONE 1 cycle later, no strobes, BUSY stays 0.
- NUM_INJ=0, NUM_STEPS=2 → 2 SPI_START pulses, no INJ_START.
- FIFO_NEAR_FULL held high for 50 cycles during INJ → no INJ_START in that window; issued 1 cycle after the release.
- ABORT asserted in INJ_WAIT at step 1, injection 1 → IDLE next cycle, STEP=1, INJ_COUNT=1, no SCAN_DONE. A following START restarts from step 0.
- With SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=100, SPI_DONE held 0 → ERROR=1 after 100 wait cycles, BUSY=0. Async BUS_RST low mid-scan clears all outputs immediately.
